// File: rtl/enum_coef_streamer.sv
// Coefficient bank that streams TAPS words, highest address first, into a FIR coefficient
// shift register. Define COEF_STREAM_READBACK_EN to add the rd_addr/rd_data readback port.
module enum_coef_streamer #(
  parameter int TAPS       = 100,
  parameter int COEF_WIDTH = 12,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  nGrst,
  input  logic                  rstn,
  input  logic                  clkEn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [COEF_WIDTH-1:0] wr_data,
  input  logic                  start,
`ifdef COEF_STREAM_READBACK_EN
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [COEF_WIDTH-1:0] rd_data,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [COEF_WIDTH-1:0] coefo,
  output logic                  coefo_valid
);

  if ((1 << ADDR_WIDTH) < TAPS) begin : g_bad_addr_width
    $error("ADDR_WIDTH cannot address TAPS coefficients");
  end

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(TAPS - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [COEF_WIDTH-1:0] bank [TAPS];

  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      state       <= IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      coefo       <= '0;
      coefo_valid <= 1'b0;
      for (int i = 0; i < TAPS; i++) bank[i] <= '0;
`ifdef COEF_STREAM_READBACK_EN
      rd_data     <= '0;
`endif
    end else if (clkEn) begin
      if (!rstn) begin
        state       <= IDLE;
        idx         <= '0;
        busy        <= 1'b0;
        done        <= 1'b0;
        err         <= 1'b0;
        coefo       <= '0;
        coefo_valid <= 1'b0;
        for (int i = 0; i < TAPS; i++) bank[i] <= '0;
`ifdef COEF_STREAM_READBACK_EN
        rd_data     <= '0;
`endif
      end else begin
        done        <= 1'b0;
        coefo_valid <= 1'b0;

        // The bank only changes in IDLE, so a running stream always sees a stable image.
        if (wr_en) begin
          if (state != IDLE || wr_addr > LAST) err <= 1'b1;
          else                                 bank[wr_addr] <= wr_data;
        end

`ifdef COEF_STREAM_READBACK_EN
        rd_data <= (rd_addr <= LAST) ? bank[rd_addr] : '0;
`endif

        case (state)
          IDLE: begin
            if (start) begin
              state <= STREAM;
              idx   <= LAST;
              busy  <= 1'b1;
            end
          end
          STREAM: begin
            coefo       <= bank[idx];
            coefo_valid <= 1'b1;
            if (start) err <= 1'b1;
            if (idx == '0) state <= DONE;
            else           idx   <= idx - ADDR_WIDTH'(1);
          end
          DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_enum_coef_streamer.sv
// Bench for enum_coef_streamer: bank/err model plus a model of the downstream shift register.
module tb_enum_coef_streamer;
  localparam int TAPS = 4;
  localparam int CW   = 12;
  localparam int AW   = 3;

  logic          clk = 1'b0;
  logic          nGrst = 1'b1;
  logic          rstn, clkEn, wr_en, start;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic          busy, done, err, coefo_valid;
  logic [CW-1:0] coefo;
`ifdef COEF_STREAM_READBACK_EN
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_data;
`endif

  int checks = 0;
  int errors = 0;
  int last_cyc;
  logic [CW-1:0] mbank [TAPS];
  logic          merr;
  logic [CW-1:0] sr [TAPS];

  always #5 clk = ~clk;

  // Downstream coefficient chain: shifts towards higher taps on each strobe.
  always @(posedge clk) begin
    if (nGrst && clkEn && coefo_valid) begin
      for (int j = TAPS - 1; j > 0; j--) sr[j] <= sr[j-1];
      sr[0] <= coefo;
    end
  end

  enum_coef_streamer #(.TAPS(TAPS), .COEF_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .nGrst(nGrst), .rstn(rstn), .clkEn(clkEn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
`ifdef COEF_STREAM_READBACK_EN
    .rd_addr(rd_addr), .rd_data(rd_data),
`endif
    .busy(busy), .done(done), .err(err), .coefo(coefo), .coefo_valid(coefo_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int j = 0; j < TAPS; j++) mbank[j] = '0;
    merr = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [CW-1:0] d);
    clkEn = 1'b1; wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (int'(a) < TAPS) mbank[a] = d;
    else                merr = 1'b1;
    checks++;
    if (err !== merr) begin
      errors++; $display("FAIL write_err addr=%0d got=%b exp=%b", a, err, merr);
    end
  endtask

  task automatic run_stream(input bit rand_gaps, input int gap_at, input int gap_len,
                            input bit with_wr, input logic [AW-1:0] waddr,
                            input logic [CW-1:0] wdata, input bit restart);
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] pc;
    logic          pv, pd;
    int k, cyc, gaps_left;
    bit fin;
`ifdef COEF_STREAM_READBACK_EN
    logic [CW-1:0] rexp;
`endif
    k = 0; cyc = 0; fin = 0; gaps_left = gap_len;
    clkEn = 1'b1; start = 1'b1;
`ifdef COEF_STREAM_READBACK_EN
    rd_addr = AW'($urandom_range(0, 7));
    rexp = (int'(rd_addr) < TAPS) ? mbank[rd_addr] : '0;
`endif
    if (with_wr) begin wr_en = 1'b1; wr_addr = waddr; wr_data = wdata; end
    tick();
    start = 1'b0; wr_en = 1'b0;
    if (with_wr) begin
      if (int'(waddr) < TAPS) mbank[waddr] = wdata;
      else                    merr = 1'b1;
    end
    for (int j = TAPS - 1; j >= 0; j--) exp_q.push_back(mbank[j]);
    checks++;
    if (busy !== 1'b1 || coefo_valid !== 1'b0) begin
      errors++; $display("FAIL start_edge busy=%b valid=%b exp busy=1 valid=0", busy, coefo_valid);
    end
    while (!fin && cyc < 60) begin
      if (rand_gaps)                          clkEn = ($urandom_range(0, 3) != 0);
      else if (k == gap_at && gaps_left > 0) begin clkEn = 1'b0; gaps_left--; end
      else                                    clkEn = 1'b1;
      start = (restart && cyc >= 1 && k == 1);
`ifdef COEF_STREAM_READBACK_EN
      checks++;
      if (rd_data !== rexp) begin
        errors++; $display("FAIL readback_stream got=%h exp=%h", rd_data, rexp);
      end
      rd_addr = AW'($urandom_range(0, 7));
      if (clkEn) rexp = (int'(rd_addr) < TAPS) ? mbank[rd_addr] : '0;
`endif
      pv = coefo_valid; pc = coefo; pd = done;
      tick();
      cyc++;
      if (clkEn) begin
        if (start && k < TAPS) merr = 1'b1;
        if (k < TAPS) begin
          checks++;
          if (coefo_valid !== 1'b1 || coefo !== exp_q[k] || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL stream_word%0d coefo=%h valid=%b busy=%b done=%b exp coefo=%h valid=1 busy=1 done=0",
                     k, coefo, coefo_valid, busy, done, exp_q[k]);
          end
          k++;
        end else begin
          checks++;
          if (done !== 1'b1 || coefo_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse done=%b valid=%b busy=%b exp done=1 valid=0 busy=0", done, coefo_valid, busy);
          end
          fin = 1;
        end
      end else begin
        checks++;
        if (coefo_valid !== pv || coefo !== pc || done !== pd) begin
          errors++;
          $display("FAIL clken_hold coefo=%h valid=%b done=%b exp coefo=%h valid=%b done=%b",
                   coefo, coefo_valid, done, pc, pv, pd);
        end
      end
      checks++;
      if (err !== merr) begin
        errors++; $display("FAIL stream_err got=%b exp=%b", err, merr);
      end
    end
    start = 1'b0; clkEn = 1'b1;
    if (!fin) begin
      checks++; errors++; $display("FAIL stream_timeout got=%0d words exp=%0d", k, TAPS);
    end
    last_cyc = cyc;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || coefo_valid !== 1'b0) begin
      errors++; $display("FAIL after_done done=%b busy=%b valid=%b exp all 0", done, busy, coefo_valid);
    end
    for (int j = 0; j < TAPS; j++) begin
      checks++;
      if (sr[j] !== mbank[j]) begin
        errors++; $display("FAIL chain_tap%0d got=%h exp=%h", j, sr[j], mbank[j]);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1; clkEn = 1'b1; wr_en = 1'b0; start = 1'b0; wr_addr = '0; wr_data = '0;
`ifdef COEF_STREAM_READBACK_EN
    rd_addr = '0;
`endif
    for (int j = 0; j < TAPS; j++) sr[j] = '0;
    #2 nGrst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || coefo !== '0 || coefo_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b done=%b err=%b coefo=%h valid=%b exp all 0", busy, done, err, coefo, coefo_valid);
    end
`ifdef COEF_STREAM_READBACK_EN
    checks++;
    if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
`endif
    tick(); tick();
    nGrst = 1'b1;
    clear_model();
    tick();
    checks++;
    if (busy !== 1'b0 || coefo_valid !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy=%b valid=%b err=%b exp 0", busy, coefo_valid, err);
    end
  endtask

  task automatic test_basic();
    for (int j = 0; j < TAPS; j++) do_write(AW'(j), CW'(12'h011 * (j + 1)));
    run_stream(0, -1, 0, 0, '0, '0, 0);
    checks++;
    if (last_cyc != TAPS + 1) begin
      errors++; $display("FAIL basic_done_cycle got=n+%0d exp=n+%0d", last_cyc, TAPS + 1);
    end
  endtask

  task automatic test_clken_gap();
    run_stream(0, 2, 2, 0, '0, '0, 0);
    checks++;
    if (last_cyc != 7) begin
      errors++; $display("FAIL gap_done_cycle got=n+%0d exp=n+7", last_cyc);
    end
  endtask

  task automatic test_bad_addr();
    do_write(AW'(5), 12'hABC);
    run_stream(0, -1, 0, 0, '0, '0, 0);
    rstn = 1'b0; clkEn = 1'b0;
    tick();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL rstn_gated got=%b exp=1", err); end
    clkEn = 1'b1;
    tick();
    rstn = 1'b1;
    clear_model();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || coefo_valid !== 1'b0) begin
      errors++; $display("FAIL rstn_clear err=%b busy=%b valid=%b exp 0", err, busy, coefo_valid);
    end
  endtask

  task automatic test_start_with_write();
    for (int j = 0; j < TAPS; j++) do_write(AW'(j), CW'(12'h011 * (j + 1)));
    run_stream(0, -1, 0, 1, AW'(3), 12'h7FF, 1);
  endtask

  task automatic test_abort();
    for (int j = 0; j < TAPS; j++) do_write(AW'(j), CW'($urandom_range(1, 4095)));
    clkEn = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (coefo_valid !== 1'b1 || coefo !== mbank[1]) begin
      errors++; $display("FAIL abort_third_word coefo=%h valid=%b exp coefo=%h valid=1", coefo, coefo_valid, mbank[1]);
    end
    #2 nGrst = 1'b0;
    #1;
    clear_model();
    checks++;
    if (coefo_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || coefo !== '0) begin
      errors++;
      $display("FAIL abort_async valid=%b busy=%b done=%b err=%b coefo=%h exp all 0", coefo_valid, busy, done, err, coefo);
    end
    tick(); tick();
    nGrst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (done !== 1'b0 || coefo_valid !== 1'b0) begin
        errors++; $display("FAIL abort_no_done cycle%0d done=%b valid=%b exp 0", c, done, coefo_valid);
      end
    end
    run_stream(0, -1, 0, 0, '0, '0, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int nw;
      nw = $urandom_range(0, 6);
      for (int w = 0; w < nw; w++) do_write(AW'($urandom_range(0, 7)), CW'($urandom));
      run_stream(1, -1, 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), CW'($urandom), 0);
    end
  endtask

`ifdef COEF_STREAM_READBACK_EN
  task automatic test_readback();
    clkEn = 1'b1; rd_addr = AW'(2);
    tick();
    checks++;
    if (rd_data !== mbank[2]) begin errors++; $display("FAIL readback_addr2 got=%h exp=%h", rd_data, mbank[2]); end
    rd_addr = AW'(6);
    tick();
    checks++;
    if (rd_data !== '0) begin errors++; $display("FAIL readback_addr6 got=%h exp=0", rd_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_clken_gap();
    test_bad_addr();
    test_start_with_write();
`ifdef COEF_STREAM_READBACK_EN
    test_readback();
`endif
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/enum_coef_streamer.md
Name: enum_coef_streamer

Overview:
- Transmit side of the reloadable-coefficient serial link.
- A host writes coefficients by address into a local bank. On a start command, the block streams all TAPS coefficients out as coefo/coefo_valid.
- Output pins connect directly to coefi/coefi_valid of the FIR coefficient shift register. Ordering guarantees that after the stream, shift register tap j holds bank[j].
- Sits between the host register interface and the FIR coefficient chain, on the FIR clock.

Parameters:
- TAPS, 100, number of coefficients in bank and in one stream.
- COEF_WIDTH, 12, coefficient width in bits.
- ADDR_WIDTH, 7, bank address width. Legal only if 2**ADDR_WIDTH >= TAPS.

Ports:
- clk  in  1  system clock, rising edge.
- nGrst  in  1  asynchronous active-low global reset.
- rstn  in  1  synchronous active-low clear, qualified by clkEn.
- clkEn  in  1  clock enable. All state holds when low.
- wr_en  in  1  bank write strobe.
- wr_addr  in  ADDR_WIDTH  bank write address.
- wr_data  in  COEF_WIDTH  coefficient to write.
- start  in  1  begin streaming, sampled as a level.
- busy  out  1  high while in STREAM.
- done  out  1  one-cycle pulse after the last coefficient is emitted.
- err  out  1  sticky error flag; cleared by rstn or nGrst.
- coefo  out  COEF_WIDTH  coefficient to the shift register.
- coefo_valid  out  1  shift strobe to the shift register.

Behaviour:
- Reset:
  - nGrst low (asynchronous) clears the bank, state=IDLE, busy=0, done=0, err=0, coefo=0, coefo_valid=0.
  - rstn low with clkEn high gives the same result, synchronously.
- clkEn low: no state, bank, or output register changes. The sink shifts only when clkEn is high, so held outputs are harmless.
- Writes (clkEn=1, state IDLE, wr_en=1):
  - wr_addr < TAPS: bank[wr_addr] <= wr_data.
  - wr_addr >= TAPS: write dropped, err <= 1.
  - wr_en while busy: write dropped, err <= 1. The bank is never modified mid-stream.
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - start=1 -> STREAM; idx <= TAPS-1; busy <= 1.
  - start=1 together with wr_en=1: the write commits first, then the stream begins. The stream includes the new value.
- STREAM, each clkEn cycle:
  - coefo <= bank[idx]; coefo_valid <= 1.
  - idx>0: idx <= idx-1.
  - idx==0: -> DONE.
  - start while in STREAM: ignored, err <= 1.
- DONE, one cycle: done <= 1, busy <= 0, coefo_valid <= 0, -> IDLE.
- Outputs are registered. With start sampled at edge n and clkEn held high:
  - coefo_valid is high on cycles n+1 .. n+TAPS.
  - Emission order is bank[TAPS-1] first, bank[0] last.
  - done is high on cycle n+TAPS+1.
- When idle, coefo_valid=0 and coefo holds its last value.
- Mid-stream rstn or nGrst aborts immediately. coefo_valid drops on the next edge (synchronous) or at once (asynchronous), and no done pulse is issued.
- idx width is ADDR_WIDTH; idx is never decremented below 0.

Optional Feature:
- Macro: COEF_STREAM_READBACK_EN.
- When defined, adds ports rd_addr (in, ADDR_WIDTH) and rd_data (out, COEF_WIDTH).
  - rd_data <= bank[rd_addr] one clkEn cycle after rd_addr is applied; 0 if rd_addr >= TAPS.
  - Reads are legal in any state and do not disturb streaming.
- When undefined, the readback ports and logic are absent.

Test Plan:
- TAPS=4, COEF_WIDTH=12. Write bank = {0x011,0x022,0x033,0x044} at addresses 0..3, pulse start at edge n -> coefo = 0x044, 0x033, 0x022, 0x011 on n+1..n+4 with coefo_valid=1; done=1 at n+5. Chained coef sr then holds tap0=0x011 .. tap3=0x044.
- Same stream with clkEn low for 2 cycles after the 2nd coefficient -> coefo stays 0x033 with valid held. The sequence resumes unbroken: total 4 shifts, done at n+7.
- wr_en with wr_addr=5 in IDLE -> bank unchanged, err=1. rstn pulse -> err=0.
- start and wr_en(addr 3, 0x7FF) in the same cycle -> first emitted coefo=0x7FF. A second start at n+2 -> err=1 and the stream still completes 4 words.
- nGrst asserted during the 3rd coefficient -> coefo_valid=0, busy=0, bank cleared, no done. After release, start streams 0x000 x4.
- COEF_STREAM_READBACK_EN defined: rd_addr=2 -> rd_data=0x033 one cycle later, including during STREAM. rd_addr=6 -> 0.
